dadda_reduce_8x8: RTL

- Downstream consumer of the 8x8 partial-product generator. Takes its 64 AND-terms pp[i][j] (weight 2^(i+j)) and reduces them Dadda-style with two layers of 4:2 compressors, 8 rows to 4 to 2.
- A final carry-propagate adder produces the 16-bit unsigned product.
- Pipelined, with a valid/ready handshake and a sideband tag carried alongside each product.

---
 rtl/dadda_reduce_8x8.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dadda_reduce_8x8.sv
// dadda_reduce_8x8: pipelined 8x8 partial-product reducer.
// 8 rows -> 4 rows -> 2 rows via two layers of 4:2 compressors, then a 16-bit CPA.
// Valid/ready handshake with a global stall; a sideband tag travels with each product.
// Optional macro DADDA_SELFCHECK_EN: behavioural reference sum piped alongside the data
// and compared at the output stage; a mismatch sets the sticky err flag.
module dadda_reduce_8x8 #(
    parameter int unsigned PIPE_MID = 1,
    parameter int unsigned TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0][7:0]   pp,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       product,
    output logic [TAG_W-1:0]  out_tag,
    output logic              err
);

    // Row-wise 4:2 compressor: returns {carry_row, sum_row} with a + b + c + d == sum + carry
    // (mod 2^16). The internal carry chain runs from bit k to bit k+1.
    function automatic logic [31:0] compress42(input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] c, input logic [15:0] d);
        logic [15:0] s;
        logic [15:0] cy;
        logic        cin;
        logic        t;
        logic        co;
        cin = 1'b0;
        for (int k = 0; k < 16; k++) begin
            t     = a[k] ^ b[k] ^ c[k];
            co    = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
            s[k]  = t ^ d[k] ^ cin;
            cy[k] = (t & d[k]) | (t & cin) | (d[k] & cin);
            cin   = co;
        end
        return {cy[14:0], 1'b0, s};
    endfunction

    logic                w_stall;
    logic                w_accept;
    logic                r_s1_v;
    logic [7:0][7:0]     r_s1_pp;
    logic [TAG_W-1:0]    r_s1_tag;
    logic [15:0]         w_rows [8];
    logic [15:0]         w_l1_s0, w_l1_c0, w_l1_s1, w_l1_c1;
    logic                w_s2_v;
    logic [15:0]         w_s2_r0, w_s2_r1, w_s2_r2, w_s2_r3;
    logic [TAG_W-1:0]    w_s2_tag;
    logic [15:0]         w_l2_s, w_l2_c, w_sum;
    logic                w_s3_load;
    logic                r_out_valid;
    logic [15:0]         r_product;
    logic [TAG_W-1:0]    r_out_tag;

    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign out_tag   = r_out_tag;

    // S1 valid: follows in_valid whenever the pipeline advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
        end else if (!w_stall) begin
            r_s1_v <= in_valid;
        end
    end

    // S1 data: capture operands and tag on acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_pp  <= pp;
            r_s1_tag <= in_tag;
        end
    end

    // First layer: rows 0-3 and rows 4-7 each compressed 4 -> 2
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_rows[i] = {8'b0, r_s1_pp[i]} << i;
        end
        {w_l1_c0, w_l1_s0} = compress42(w_rows[0], w_rows[1], w_rows[2], w_rows[3]);
        {w_l1_c1, w_l1_s1} = compress42(w_rows[4], w_rows[5], w_rows[6], w_rows[7]);
    end

    if (PIPE_MID != 0) begin : g_mid
        logic             r_s2_v;
        logic [15:0]      r_s2_r0, r_s2_r1, r_s2_r2, r_s2_r3;
        logic [TAG_W-1:0] r_s2_tag;

        // S2 valid: advances with the global stall
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_v <= 1'b0;
            end else if (!w_stall) begin
                r_s2_v <= r_s1_v;
            end
        end

        // S2 data: four intermediate rows plus tag
        always_ff @(posedge clk) begin
            if (!w_stall && r_s1_v) begin
                r_s2_r0  <= w_l1_s0;
                r_s2_r1  <= w_l1_c0;
                r_s2_r2  <= w_l1_s1;
                r_s2_r3  <= w_l1_c1;
                r_s2_tag <= r_s1_tag;
            end
        end

        assign w_s2_v   = r_s2_v;
        assign w_s2_r0  = r_s2_r0;
        assign w_s2_r1  = r_s2_r1;
        assign w_s2_r2  = r_s2_r2;
        assign w_s2_r3  = r_s2_r3;
        assign w_s2_tag = r_s2_tag;
    end else begin : g_nomid
        assign w_s2_v   = r_s1_v;
        assign w_s2_r0  = w_l1_s0;
        assign w_s2_r1  = w_l1_c0;
        assign w_s2_r2  = w_l1_s1;
        assign w_s2_r3  = w_l1_c1;
        assign w_s2_tag = r_s1_tag;
    end

    // Second layer 4 -> 2 followed by the carry-propagate adder
    always_comb begin
        {w_l2_c, w_l2_s} = compress42(w_s2_r0, w_s2_r1, w_s2_r2, w_s2_r3);
        w_sum            = w_l2_s + w_l2_c;
    end

    assign w_s3_load = !w_stall && w_s2_v;

    // S3: output valid, product and tag; product holds while the pipeline is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_out_tag   <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_s2_v;
            if (w_s2_v) begin
                r_product <= w_sum;
                r_out_tag <= w_s2_tag;
            end
        end
    end

`ifdef DADDA_SELFCHECK_EN
    logic [15:0] w_in_ref;
    logic [15:0] r_s1_ref;
    logic [15:0] w_s2_ref;
    logic        r_err;

    // Behavioural reference: plain weighted sum of the partial-product rows
    always_comb begin
        w_in_ref = '0;
        for (int i = 0; i < 8; i++) begin
            w_in_ref = w_in_ref + ({8'b0, pp[i]} << i);
        end
    end

    // Reference captured alongside S1 data
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_ref <= w_in_ref;
        end
    end

    if (PIPE_MID != 0) begin : g_ref_mid
        logic [15:0] r_s2_ref;
        // Reference follows the S2 data register
        always_ff @(posedge clk) begin
            if (!w_stall && r_s1_v) begin
                r_s2_ref <= r_s1_ref;
            end
        end
        assign w_s2_ref = r_s2_ref;
    end else begin : g_ref_nomid
        assign w_s2_ref = r_s1_ref;
    end

    // Sticky error on any CPA/reference disagreement at S3 load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_s3_load && (w_sum != w_s2_ref)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
